// File: rtl/sqrd_issue_scheduler.sv
// Frame scheduler for the sorted-QR decompose pipeline: round-robin issue into the free-running
// pipeline, latency-aligned {src,seq} tag tracking and a credit-guarded output tag FIFO.

module sqrd_issue_scheduler_chk #(
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input logic        clk,
    input logic        rst,
    input logic        wr_en,
    input logic        full,
    input logic [AW:0] count
);
    // Credits must make a write into a full tag FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(wr_en && full));
    a_count_range: assert property (@(posedge clk) disable iff (!rst) int'(count) <= DEPTH);
endmodule

module sqrd_issue_scheduler #(
    parameter int  NREQ       = 2,
    parameter int  LAT        = 24,
    parameter int  OBUF_DEPTH = 8,
    parameter int  SEQ_WL     = 4,
    localparam int SW         = $clog2(NREQ),
    localparam int AW         = $clog2(OBUF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    output logic              issue,
    output logic [SW-1:0]     issue_sel,
    output logic              buf_wr_en,
    output logic [AW-1:0]     buf_wr_addr,
    output logic [AW-1:0]     buf_rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SW-1:0]     out_src,
    output logic [SEQ_WL-1:0] out_seq,
    output logic              busy
);
    localparam int          AW1        = AW + 1;
    localparam logic [AW:0] FULL_COUNT = AW1'(OBUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                seq_clr_s;
    logic [SW-1:0]       rr_r;
    logic [SEQ_WL-1:0]   seq_r      [NREQ];
    logic [AW:0]         count_r;
    logic [AW:0]         wr_ptr_r;
    logic [AW:0]         rd_ptr_r;
    logic                pipe_v_r   [LAT];
    logic [SW-1:0]       pipe_src_r [LAT];
    logic [SEQ_WL-1:0]   pipe_seq_r [LAT];
    logic [SW-1:0]       fifo_src_r [OBUF_DEPTH];
    logic [SEQ_WL-1:0]   fifo_seq_r [OBUF_DEPTH];
    logic [SW-1:0]       grant_s;
    logic [SW-1:0]       cand_s;
    logic                issue_s;
    logic                pop_s;
    logic                wr_en_s;
    logic                full_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; sequence numbers restart whenever the scheduler falls back to idle.
    always_comb begin
        state_s   = state_r;
        seq_clr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_s = ST_RUN;
                else        state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!enable) state_s = ST_DRAIN;
                else         state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_s = ST_RUN;
                end else if (count_r == {AW1{1'b0}}) begin
                    state_s   = ST_IDLE;
                    seq_clr_s = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Round-robin pick; scanning from the far end lets the candidate nearest rr+1 win.
    always_comb begin
        grant_s = {SW{1'b0}};
        cand_s  = {SW{1'b0}};
        for (int k = NREQ; k >= 1; k--) begin
            cand_s  = SW'((int'(rr_r) + k) % NREQ);
            grant_s = req_valid[cand_s] ? cand_s : grant_s;
        end
        issue_s = (state_r == ST_RUN) && (|req_valid) && (count_r < FULL_COUNT);
    end

    assign wr_en_s = pipe_v_r[LAT-1];
    assign pop_s   = out_valid & out_ready;
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

    // Arbiter pointer and per-requester sequence counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_r <= SW'(NREQ - 1);
            for (int i = 0; i < NREQ; i++) seq_r[i] <= {SEQ_WL{1'b0}};
        end else if (seq_clr_s) begin
            for (int i = 0; i < NREQ; i++) seq_r[i] <= {SEQ_WL{1'b0}};
        end else if (issue_s) begin
            rr_r           <= grant_s;
            seq_r[grant_s] <= seq_r[grant_s] + SEQ_WL'(1'b1);
        end else begin
            rr_r <= rr_r;
        end
    end

    // Credit counter: frames in flight plus frames waiting in the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {AW1{1'b0}};
        end else begin
            case ({issue_s, pop_s})
                2'b10:   count_r <= count_r + AW1'(1'b1);
                2'b01:   count_r <= count_r - AW1'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tag shift register mirroring the pipeline latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_v_r[i]   <= 1'b0;
                pipe_src_r[i] <= {SW{1'b0}};
                pipe_seq_r[i] <= {SEQ_WL{1'b0}};
            end
        end else begin
            pipe_v_r[0]   <= issue_s;
            pipe_src_r[0] <= grant_s;
            pipe_seq_r[0] <= seq_r[grant_s];
            for (int i = 1; i < LAT; i++) begin
                pipe_v_r[i]   <= pipe_v_r[i-1];
                pipe_src_r[i] <= pipe_src_r[i-1];
                pipe_seq_r[i] <= pipe_seq_r[i-1];
            end
        end
    end

    // Tag FIFO and its wrap-bit pointers; entries are cleared so outputs read 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW1{1'b0}};
            rd_ptr_r <= {AW1{1'b0}};
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                fifo_src_r[i] <= {SW{1'b0}};
                fifo_seq_r[i] <= {SEQ_WL{1'b0}};
            end
        end else begin
            if (wr_en_s) begin
                fifo_src_r[wr_ptr_r[AW-1:0]] <= pipe_src_r[LAT-1];
                fifo_seq_r[wr_ptr_r[AW-1:0]] <= pipe_seq_r[LAT-1];
                wr_ptr_r                     <= wr_ptr_r + AW1'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW1'(1'b1);
            else       rd_ptr_r <= rd_ptr_r;
        end
    end

    assign issue       = issue_s;
    assign issue_sel   = issue_s ? grant_s : {SW{1'b0}};
    assign req_ready   = issue_s ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_s) : {NREQ{1'b0}};
    assign buf_wr_en   = wr_en_s;
    assign buf_wr_addr = wr_ptr_r[AW-1:0];
    assign buf_rd_addr = rd_ptr_r[AW-1:0];
    assign out_valid   = (wr_ptr_r != rd_ptr_r);
    assign out_src     = fifo_src_r[rd_ptr_r[AW-1:0]];
    assign out_seq     = fifo_seq_r[rd_ptr_r[AW-1:0]];
    assign busy        = (state_r != ST_IDLE);

    sqrd_issue_scheduler_chk #(
        .AW    (AW),
        .DEPTH (OBUF_DEPTH)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en_s),
        .full  (full_s),
        .count (count_r)
    );
endmodule

// File: tb/tb_sqrd_issue_scheduler.sv
// Self-checking bench for sqrd_issue_scheduler: a queue-based frame model checked every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_sqrd_issue_scheduler;
    localparam int NREQ  = 2;
    localparam int LAT   = 24;
    localparam int DEPTH = 8;
    localparam int SEQM  = 16;

    logic       clk, rst, enable, out_ready;
    logic [1:0] req_valid, req_ready;
    logic       issue, issue_sel, buf_wr_en, out_valid, out_src, busy;
    logic [2:0] buf_wr_addr, buf_rd_addr;
    logic [3:0] out_seq;

    int errors = 0;
    int checks = 0;

    sqrd_issue_scheduler #(.NREQ(NREQ), .LAT(LAT), .OBUF_DEPTH(DEPTH), .SEQ_WL(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid), .req_ready(req_ready),
        .issue(issue), .issue_sel(issue_sel), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
        .buf_rd_addr(buf_rd_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src), .out_seq(out_seq), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: frames are queue entries stamped with their issue cycle.
    typedef struct {int t; int src; int seq;} frame_t;
    frame_t infl[$];
    frame_t obuf[$];
    int m_state, m_rr, m_wr, m_rd, cyc;
    int m_seq [NREQ];

    function automatic void m_reset();
        m_state = 0;
        m_rr    = NREQ - 1;
        m_wr    = 0;
        m_rd    = 0;
        for (int i = 0; i < NREQ; i++) m_seq[i] = 0;
        infl.delete();
        obuf.delete();
    endfunction

    function automatic void m_decide(input logic [1:0] rv, output bit iss, output int g);
        int idx;
        g   = 0;
        idx = m_rr;
        iss = (m_state == 1) && (rv != 2'b00) && (infl.size() + obuf.size() < DEPTH);
        for (int n = 0; n < NREQ; n++) begin
            idx = (idx + 1) % NREQ;
            if (rv[idx]) begin
                g = idx;
                break;
            end
        end
    endfunction

    // Model advance on each active edge.
    always @(posedge clk) begin
        bit iss;
        int g, cnt;
        if (!rst) begin
            m_reset();
        end else begin
            m_decide(req_valid, iss, g);
            cnt = infl.size() + obuf.size();
            if (obuf.size() > 0 && out_ready) begin
                void'(obuf.pop_front());
                m_rd++;
            end
            if (infl.size() > 0 && infl[0].t + LAT == cyc) begin
                obuf.push_back(infl.pop_front());
                m_wr++;
            end
            if (iss) begin
                infl.push_back('{t: cyc, src: g, seq: m_seq[g]});
                m_seq[g] = (m_seq[g] + 1) % SEQM;
                m_rr     = g;
            end
            case (m_state)
                0: if (enable) m_state = 1;
                1: if (!enable) m_state = 2;
                default: begin
                    if (enable) m_state = 1;
                    else if (cnt == 0) begin
                        m_state = 0;
                        for (int i = 0; i < NREQ; i++) m_seq[i] = 0;
                    end
                end
            endcase
        end
        cyc++;
    end

    // Compare process: every output against the model, away from the active edge.
    always @(negedge clk) begin
        bit iss;
        int g;
        bit wr;
        if (!rst) begin
            m_reset();
            chk("rst_req_ready", req_ready, 0);
            chk("rst_issue", issue, 0);
            chk("rst_issue_sel", issue_sel, 0);
            chk("rst_buf_wr_en", buf_wr_en, 0);
            chk("rst_wr_addr", buf_wr_addr, 0);
            chk("rst_rd_addr", buf_rd_addr, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_src", out_src, 0);
            chk("rst_out_seq", out_seq, 0);
            chk("rst_busy", busy, 0);
        end else begin
            m_decide(req_valid, iss, g);
            wr = infl.size() > 0 && infl[0].t + LAT == cyc;
            chk("issue", issue, int'(iss));
            chk("req_ready", req_ready, iss ? (1 << g) : 0);
            chk("issue_sel", issue_sel, iss ? g : 0);
            chk("buf_wr_en", buf_wr_en, int'(wr));
            if (wr) chk("buf_wr_addr", buf_wr_addr, m_wr % DEPTH);
            chk("buf_rd_addr", buf_rd_addr, m_rd % DEPTH);
            chk("out_valid", out_valid, int'(obuf.size() > 0));
            if (obuf.size() > 0) begin
                chk("out_src", out_src, obuf[0].src);
                chk("out_seq", out_seq, obuf[0].seq);
            end
            chk("busy", busy, int'(m_state != 0));
        end
    end

    task automatic next(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n, pops, issued;
        int sel[4];
        int seqs[$];
        rst = 1'b0; enable = 1'b0; req_valid = 2'b00; out_ready = 1'b0;
        next(3);
        rst = 1'b1;
        next(2);

        // Single frame: issue at T, write at T+24, head visible at T+25.
        enable = 1'b1;
        next(1);
        req_valid = 2'b01;
        @(negedge clk);
        chk("sf_req_ready", req_ready, 1);
        chk("sf_issue_sel", issue_sel, 0);
        next(1);
        req_valid = 2'b00;
        repeat (23) @(posedge clk);
        @(negedge clk);
        chk("sf_wr_en", buf_wr_en, 1);
        chk("sf_wr_addr", buf_wr_addr, 0);
        chk("sf_valid_early", out_valid, 0);
        @(negedge clk);
        chk("sf_out_valid", out_valid, 1);
        chk("sf_out_src", out_src, 0);
        chk("sf_out_seq", out_seq, 0);
        next(1);
        out_ready = 1'b1;
        next(2);

        // Reset with three frames in flight: they must never reach the buffer.
        req_valid = 2'b01;
        next(3);
        req_valid = 2'b00;
        next(5);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_out_valid", out_valid, 0);
        next(2);
        enable = 1'b0;
        rst    = 1'b1;
        n = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(negedge clk);
            if (buf_wr_en) n++;
        end
        chk("rstmid_no_write", n, 0);
        next(1);

        // Credits: exactly eight issues with a stalled consumer, one more per pop.
        enable = 1'b1; out_ready = 1'b0;
        next(1);
        req_valid = 2'b01;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready[0]) n++;
            next(1);
        end
        chk("credit_issues", n, 8);
        out_ready = 1'b1;
        next(1);
        out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) n++;
            next(1);
        end
        chk("credit_one_more", n, 1);
        req_valid = 2'b00; out_ready = 1'b1;
        next(LAT + 12);

        // Drain: five frames in flight, then enable drops.
        out_ready = 1'b0; req_valid = 2'b01;
        next(5);
        enable = 1'b0; req_valid = 2'b00;
        next(1);
        req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) n++;
            next(1);
        end
        chk("drain_no_issue", n, 0);
        @(negedge clk);
        chk("drain_busy", busy, 1);
        next(1);
        out_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (out_valid) pops++;
            next(1);
        end
        chk("drain_pops", pops, 5);
        chk("drain_idle", busy, 0);
        next(1);
        req_valid = 2'b00;

        // Sequence wrap: seventeen frames from requester 1 after the drain cleared the counters.
        enable = 1'b1; req_valid = 2'b10;
        issued = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready[1]) issued++;
            if (out_valid && out_ready) seqs.push_back(int'(out_seq));
            if (seqs.size() >= 17) break;
            next(1);
            if (issued >= 17) req_valid = 2'b00;
        end
        chk("wrap_frames", seqs.size(), 17);
        if (seqs.size() >= 17) begin
            chk("wrap_first", seqs[0], 0);
            chk("wrap_last_before", seqs[15], 15);
            chk("wrap_rollover", seqs[16], 0);
        end
        next(1);
        req_valid = 2'b00;
        next(4);

        // Round robin with both requesters valid; last grant was requester 1.
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sel[i] = int'(issue_sel);
            next(1);
        end
        req_valid = 2'b00;
        chk("rr_0", sel[0], 0);
        chk("rr_1", sel[1], 1);
        chk("rr_2", sel[2], 0);
        chk("rr_3", sel[3], 1);
        next(LAT + 12);

        // Randomized traffic with varying consumer throughput and one mid-run reset.
        for (int blk = 0; blk < 16; blk++) begin
            int p;
            p = $urandom_range(0, 4);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 59) == 0) enable = ~enable;
                req_valid = 2'($urandom_range(0, 3));
                out_ready = ($urandom_range(0, 3) < p);
                if (blk == 8 && i == 100) rst = 1'b0;
                if (blk == 8 && i == 103) rst = 1'b1;
                next(1);
            end
        end

        enable = 1'b0; req_valid = 2'b00; out_ready = 1'b1;
        next(LAT + 20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
